shift_pload_sio: RTL
====================

Name: shift_pload_sio

Overview:
Parametrised successor to the 8-bit parallel-load/serial-out shifter used on the CPLD byte channels. It is a full-duplex serial engine.
- Loads a WIDTH-bit word and shifts it out MSB- or LSB-first.
- Simultaneously samples a serial input bit per shift.
- Counts the shifts, then captures the received word into a parallel output register and flags completion.
- Sits between the TI-bus-side latches and the Pi-side serial clock/select lines.

Parameters:
WIDTH, 8, shift register and parallel port width; legal range 2..32.
MSB_FIRST, 1, 1 = shift out bit WIDTH-1 first and shift in at bit 0; 0 = shift out bit 0 first and shift in at bit WIDTH-1.

Ports:
clk  input  1  shift clock; all state changes on rising edge.
rst_n  input  1  asynchronous active-low reset.
select  input  1  channel select; no state changes except reset while low.
load  input  1  parallel load request; sampled only when select=1.
data  input  WIDTH  word to transmit; sampled on the load edge.
sin  input  1  serial input bit; sampled on each shift edge.
sout  output  1  current outgoing bit; combinational from the shift register end bit.
pout  output  WIDTH  last fully received word; registered.
busy  output  1  1 while a transfer is in progress.
done  output  1  sticky completion flag.
parity  output  1  even-parity bit of pout (see Optional Feature).

Behaviour:
- Reset (rst_n=0, asynchronous):
  - shift register, bit counter, pout, busy, done and parity all clear to 0.
  - sout therefore reads 0.
  - A reset mid-transfer aborts it; no capture occurs.
- Internal state:
  - shift register sr[WIDTH-1:0].
  - down-counter cnt, $clog2(WIDTH+1) bits.
- sout = sr[WIDTH-1] when MSB_FIRST=1, else sr[0].
- States, derived from busy:
  - IDLE (busy=0).
  - SHIFT (busy=1).
- Edge with select=1 and load=1, in any state (load has priority over shift):
  - sr<=data, cnt<=WIDTH, busy<=1, done<=0.
  - pout is unchanged.
  - A load while busy aborts the current transfer and restarts it.
- Edge with select=1, load=0, busy=1:
  - MSB_FIRST=1: sr<={sr[WIDTH-2:0], sin}.
  - MSB_FIRST=0: sr<={sin, sr[WIDTH-1:1]}.
  - cnt<=cnt-1.
  - If cnt was 1, this is the final shift:
    - pout<= the newly shifted value, including this edge's sin.
    - busy<=0, done<=1.
- Edge with select=1, load=0, busy=0: no change. sr holds, so sout is stable after completion (unlike the prior block, which zero-fills forever).
- Edge with select=0: no change in any state, including mid-transfer. The transfer resumes when select returns.
- Latency:
  - First data bit is valid on sout immediately after the load edge.
  - Bit k (0-based) is valid after k shift edges.
  - pout/done update on the WIDTH-th shift edge after load.
- done remains 1 until the next accepted load or reset.
- cnt never underflows; it is only decremented while busy.

Optional Feature:
Macro SHIFT_PLOAD_SIO_PARITY_EN.
- Defined:
  - parity is a register updated together with pout on the final shift: parity<=^(captured word).
  - It is cleared on reset and unchanged otherwise.
- Undefined:
  - parity is tied to 0; no extra logic.
  - All other behaviour is identical.

Test Plan:
1. WIDTH=8, MSB_FIRST=1: reset, then load data=8'hA5 with sin driven from 8'h3C MSB-first over 8 shifts -> sout sequence 1,0,1,0,0,1,0,1; after 8th edge pout=8'h3C, busy=0, done=1.
2. WIDTH=8, MSB_FIRST=0: load 8'hA5 -> sout sequence 1,0,1,0,0,1,0,1 read LSB-first (bits 0..7); sin pattern 8'h81 LSB-first -> pout=8'h81.
3. Select gap: load 8'hF0, 3 shifts, select=0 for 5 clocks, then 5 more shifts -> sout frozen during gap; pout valid only after the 8th shift edge; busy stays 1 throughout the gap.
4. Abort and reset: load 8'h55, 4 shifts, load 8'hAA -> done=0, next 8 shifts output the 8'hAA pattern. Separately, assert rst_n=0 after 3 shifts -> pout=0, busy=0, done=0, sout=0 immediately, without a clock edge.
5. Post-done hold: complete a transfer, then keep select=1, load=0 for 10 clocks -> sr, sout, pout unchanged; done stays 1. Load without select -> ignored.
6. WIDTH=16 with SHIFT_PLOAD_SIO_PARITY_EN defined: received 16'h0007 -> parity=1; received 16'h0003 -> parity=0. With the macro undefined, parity is 0 in both cases.

Source files
------------

// File: rtl/shift_pload_sio.sv
// shift_pload_sio: full-duplex parallel-load / serial-in-out shift engine.
// Loads a WIDTH-bit word, shifts it out MSB- or LSB-first while sampling
// sin on every shift, then captures the received word into pout and sets
// a sticky done flag.
// Optional build macro SHIFT_PLOAD_SIO_PARITY_EN: when defined, parity is
// a register holding the even parity of each captured word; otherwise
// parity is tied low.
module shift_pload_sio #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             select,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
  input  logic             sin,
  output logic             sout,
  output logic [WIDTH-1:0] pout,
  output logic             busy,
  output logic             done,
  output logic             parity
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [WIDTH-1:0] r_sr;
  logic [WIDTH-1:0] w_sr_next;
  logic [WIDTH-1:0] w_shifted;
  logic [WIDTH-1:0] r_pout;
  logic [WIDTH-1:0] w_pout_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_next;
  logic             r_done;
  logic             w_done_next;

  // Shift direction and outgoing bit are fixed at elaboration time.
  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {r_sr[WIDTH-2:0], sin};
      assign sout      = r_sr[WIDTH-1];
    end else begin : g_lsb_first
      assign w_shifted = {sin, r_sr[WIDTH-1:1]};
      assign sout      = r_sr[0];
    end
  endgenerate

  // Next-state logic: load beats shift; nothing moves while select is low.
  always_comb begin
    w_state_next = r_state;
    w_sr_next    = r_sr;
    w_cnt_next   = r_cnt;
    w_pout_next  = r_pout;
    w_done_next  = r_done;
    if (select) begin
      if (load) begin
        w_sr_next    = data;
        w_cnt_next   = CW'(WIDTH);
        w_state_next = SHIFT;
        w_done_next  = 1'b0;
      end else if (r_state == SHIFT) begin
        w_sr_next  = w_shifted;
        w_cnt_next = r_cnt - CW'(1);
        // Final shift: capture includes the bit sampled on this very edge.
        if (r_cnt == CW'(1)) begin
          w_pout_next  = w_shifted;
          w_state_next = IDLE;
          w_done_next  = 1'b1;
        end
      end
    end
  end

  // State register; an asynchronous reset aborts any transfer in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_sr    <= '0;
      r_cnt   <= '0;
      r_pout  <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_sr    <= w_sr_next;
      r_cnt   <= w_cnt_next;
      r_pout  <= w_pout_next;
      r_done  <= w_done_next;
    end
  end

  assign pout = r_pout;
  assign busy = (r_state == SHIFT);
  assign done = r_done;

`ifdef SHIFT_PLOAD_SIO_PARITY_EN
  logic r_parity;
  logic w_capture;

  assign w_capture = select && !load && (r_state == SHIFT) && (r_cnt == CW'(1));

  // Parity tracks pout: updated only on the capturing shift edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_parity <= 1'b0;
    end else if (w_capture) begin
      r_parity <= ^w_shifted;
    end
  end

  assign parity = r_parity;
`else
  assign parity = 1'b0;
`endif

endmodule
